// File: rtl/noise_acq_ctrl.sv
// Noise-acquisition window sequencer: settles, captures n_samp ADC samples into
// the noise buffer RAM, and otherwise serves host reads from the same RAM port.
module noise_acq_ctrl #(
  parameter int AW     = 12,
  parameter int DW     = 12,
  parameter int SETTLE = 16
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] n_samp,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t        state_q,      state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0] n_samp_q,     n_samp_d;
  logic [AW-1:0] ram_addr_q,   ram_addr_d;
  logic [DW-1:0] ram_wdata_q,  ram_wdata_d;
  logic          ram_we_q,     ram_we_d;
  logic          ram_re_q,     ram_re_d;
  logic          rd_gnt_q,     rd_gnt_d;
  logic          rd_pipe_q,    rd_pipe_d;
  logic          rd_valid_q,   rd_valid_d;
  logic [DW-1:0] rd_data_q,    rd_data_d;
  logic          busy_q,       busy_d;
  logic          done_q,       done_d;

  logic start_ok;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    n_samp_d     = n_samp_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    rd_gnt_d     = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    start_ok     = start && !abort && (state_q == ST_IDLE);

    // Read return pipe runs independently of the FSM so an in-flight read
    // still completes after a new acquisition has started.
    rd_pipe_d    = ram_re_q;
    rd_valid_d   = rd_pipe_q;
    rd_data_d    = rd_pipe_q ? ram_rdata : rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          n_samp_d     = n_samp;
          settle_cnt_d = '0;
          wr_ptr_d     = '0;
          busy_d       = 1'b1;
          state_d      = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end else if (rd_req && !start && !rd_gnt_q) begin
          rd_gnt_d   = 1'b1;
          ram_re_d   = 1'b1;
          ram_addr_d = rd_addr;
        end
      end

      ST_SETTLE: begin
        if (adc_valid) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d  = ST_CAPTURE;
            wr_ptr_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      ST_CAPTURE: begin
        if (adc_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = wr_ptr_q;
          ram_wdata_d = adc_data;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          // n_samp=0 wraps to all-ones here, giving a full 2**AW capture.
          if (wr_ptr_q == n_samp_q - 1'b1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      ram_we_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      wr_ptr_q     <= '0;
      n_samp_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      rd_gnt_q     <= 1'b0;
      rd_pipe_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      n_samp_q     <= n_samp_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      rd_gnt_q     <= rd_gnt_d;
      rd_pipe_q    <= rd_pipe_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign rd_gnt    = rd_gnt_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_noise_acq_ctrl.sv
// Self-checking bench for noise_acq_ctrl: table of acquisition scenarios plus
// hand-written reset/read/start-collision sequences, checked by scoreboards.
module tb_noise_acq_ctrl;

  localparam int AW     = 12;
  localparam int DW     = 12;
  localparam int SETTLE = 16;
  localparam int DEPTH  = 1 << AW;

  logic          clkin;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] n_samp;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  noise_acq_ctrl #(.AW(AW), .DW(DW), .SETTLE(SETTLE)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_samp    (n_samp),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .ram_rdata (ram_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Behavioural noise buffer RAM with one cycle of read latency
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clkin) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct {
    int n;
    int gap;
    int abort_after;
    int exp_writes;
    int exp_done;
    int exp_last_addr;
  } vec_t;

  wr_exp_t       wq [$];
  logic [AW-1:0] gq [$];
  logic [AW-1:0] vq [$];
  logic [DW-1:0] model_mem [DEPTH];

  int tests_run;
  int tests_failed;
  int write_cnt;
  int done_cnt;
  int last_wr_addr;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {26'd0, ram_we, ram_re, rd_gnt, rd_valid, busy, done}, 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  // Monitor: write scoreboard, read scoreboard, done/grant timing rules
  logic          prev_we;
  logic          gnt_d1;
  logic          gnt_d2;
  wr_exp_t       mon_e;
  logic [AW-1:0] mon_a;

  always @(negedge clkin) begin
    if (!rst_n) begin
      prev_we = 1'b0;
      gnt_d1  = 1'b0;
      gnt_d2  = 1'b0;
    end else begin
      if (ram_we || ram_re) checkOutput("we_re_excl", 32'(ram_we & ram_re), 32'd0);
      if (ram_we) begin
        write_cnt++;
        last_wr_addr = int'(ram_addr);
        checkOutput("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          mon_e = wq.pop_front();
          checkOutput("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
          checkOutput("wr_data", 32'(ram_wdata), 32'(mon_e.data));
        end
      end
      if (rd_gnt) begin
        checkOutput("gnt_only_idle", 32'(busy | done), 32'd0);
        checkOutput("gnt_ram_re", 32'(ram_re), 32'd1);
        checkOutput("gnt_pending", 32'(gq.size() != 0), 32'd1);
        if (gq.size() != 0) begin
          mon_a = gq.pop_front();
          checkOutput("gnt_ram_addr", 32'(ram_addr), 32'(mon_a));
          vq.push_back(mon_a);
        end
      end
      if (rd_valid || gnt_d2) begin
        checkOutput("rd_latency", 32'(rd_valid), 32'(gnt_d2));
        if (rd_valid && vq.size() != 0) begin
          mon_a = vq.pop_front();
          checkOutput("rd_data", 32'(rd_data), 32'(model_mem[mon_a]));
        end
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_after_last_we", 32'(prev_we), 32'd1);
        checkOutput("done_busy_low", 32'(busy), 32'd0);
        checkOutput("done_all_written", 32'(wq.size()), 32'd0);
      end
      prev_we = ram_we;
      gnt_d2  = gnt_d1;
      gnt_d1  = rd_gnt;
    end
  end

  always @(negedge clkin) begin
    if (rst_n) begin
      assert (!(ram_we && ram_re)) else $error("[TB] FAIL we_re_assert: ram_we and ram_re both 1");
    end
  end

  // One acquisition: start, SETTLE+n strobes every 'gap' cycles, optional abort
  task automatic applyStimulus(input int n, input int gap, input int abort_after);
    int nw;
    int total;
    wr_exp_t e;
    logic [DW-1:0] d;
    nw     = (n == 0) ? DEPTH : n;
    total  = SETTLE + nw;
    n_samp = n[AW-1:0];
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < total; k++) begin
      if (abort_after >= 0 && k == SETTLE + abort_after) begin
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_we", 32'(ram_we), 32'd0);
        for (int j = 0; j < 3; j++) begin
          repeat (gap - 1) tick();
          adc_valid = 1'b1;
          adc_data  = DW'($urandom);
          tick();
          adc_valid = 1'b0;
        end
        break;
      end
      repeat (gap - 1) tick();
      d         = DW'($urandom);
      adc_valid = 1'b1;
      adc_data  = d;
      if (k >= SETTLE) begin
        e.addr = AW'(k - SETTLE);
        e.data = d;
        wq.push_back(e);
        model_mem[e.addr] = d;
      end
      tick();
      adc_valid = 1'b0;
    end
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
    checkOutput("acq_returns_idle", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic issueRead(input logic [AW-1:0] addr, input int bound);
    logic got;
    got     = 1'b0;
    rd_addr = addr;
    rd_req  = 1'b1;
    gq.push_back(addr);
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (rd_gnt) got = 1'b1;
    end
    rd_req = 1'b0;
    checkOutput("rd_gnt_seen", 32'(got), 32'd1);
    repeat (3) tick();
  endtask

  vec_t vecs [5];
  int   prev_w;
  int   prev_d;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8,  4, -1, 8,     1, 7};
    vecs[1] = '{0,  2, -1, DEPTH, 1, DEPTH - 1};
    vecs[2] = '{10, 3,  3, 3,     0, 2};
    vecs[3] = '{5,  1, -1, 5,     1, 4};
    vecs[4] = '{1,  2, -1, 1,     1, 0};

    tests_run = 0; tests_failed = 0; write_cnt = 0; done_cnt = 0; last_wr_addr = -1;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; n_samp = '0;
    adc_valid = 1'b0; adc_data = '0; rd_req = 1'b0; rd_addr = '0;

    repeat (3) @(posedge clkin);
    #1;
    checkAllZero("reset");
    @(negedge clkin);
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of a capture, during a ram_we cycle
    n_samp = AW'(8);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < SETTLE + 2; k++) begin
      tick();
      adc_valid = 1'b1;
      adc_data  = DW'($urandom);
      if (k >= SETTLE) wq.push_back('{AW'(k - SETTLE), adc_data});
      tick();
      adc_valid = 1'b0;
    end
    checkOutput("t1_we_before_reset", 32'(ram_we), 32'd1);
    #3 rst_n = 1'b0;
    #2 checkAllZero("t1_async");
    wq.delete();
    repeat (2) @(posedge clkin);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("t1_idle_after_release", 32'(busy), 32'd0);

    for (int r = 0; r < 5; r++) begin
      prev_w = write_cnt;
      prev_d = done_cnt;
      applyStimulus(vecs[r].n, vecs[r].gap, vecs[r].abort_after);
      repeat (2) tick();
      checkOutput("row_writes", 32'(write_cnt - prev_w), 32'(vecs[r].exp_writes));
      checkOutput("row_done", 32'(done_cnt - prev_d), 32'(vecs[r].exp_done));
      checkOutput("row_last_addr", 32'(last_wr_addr), 32'(vecs[r].exp_last_addr));
      checkOutput("row_queue_empty", 32'(wq.size()), 32'd0);
    end

    // Host read requested during an acquisition stalls until IDLE
    prev_d = done_cnt;
    fork
      applyStimulus(8, 4, -1);
      begin
        repeat (30) tick();
        issueRead(AW'(5), 400);
      end
    join
    checkOutput("t5_done", 32'(done_cnt - prev_d), 32'd1);

    // start and rd_req in the same IDLE cycle: start wins, read follows
    fork
      applyStimulus(4, 2, -1);
      issueRead(AW'(10), 300);
    join

    // start arriving while a granted read is still in flight
    fork
      issueRead(AW'(20), 20);
      begin
        tick();
        applyStimulus(3, 2, -1);
      end
    join

    // second start while busy is ignored
    prev_w = write_cnt;
    prev_d = done_cnt;
    fork
      applyStimulus(6, 3, -1);
      begin
        repeat (55) tick();
        n_samp = AW'(2);
        start  = 1'b1;
        tick();
        start  = 1'b0;
      end
    join
    repeat (4) tick();
    checkOutput("t6_writes", 32'(write_cnt - prev_w), 32'd6);
    checkOutput("t6_done", 32'(done_cnt - prev_d), 32'd1);
    checkOutput("t6_busy_idle", 32'(busy), 32'd0);
    checkOutput("reads_drained", 32'(gq.size() + vq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
